rom_port_arbiter: RTL and testbench
===================================

# rom_port_arbiter

Shares one single-port, one-cycle-latency instruction ROM between the CPU instruction-fetch requester and the data-load requester that reads constants from ROM. Sits between the CPU's fetch and memory-stage ROM accesses and the ROM array. Replaces the dual combinational ROM read ports with one registered port. Provides per-requester req/ack handshakes, fixed data-first priority with a fetch starvation guard, and address-range/alignment checking.

## Interface
Parameters:
- AW, 7, ROM word-index width (ROM depth 2**AW words)
- DW, 32, data width
- MAX_DATA_RUN, 2, max consecutive data grants while fetch is waiting (1..15)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  32  fetch byte address
- if_ack  out  1  fetch granted this cycle (combinational)
- if_rvalid  out  1  fetch data valid (registered)
- if_rdata  out  DW  fetch data
- if_err  out  1  with if_rvalid: address out of range or misaligned
- d_req  in  1  data-read request; held until d_ack
- d_addr  in  32  data byte address
- d_ack  out  1  data granted this cycle (combinational)
- d_rvalid  out  1  data valid (registered)
- d_rdata  out  DW  data
- d_err  out  1  with d_rvalid: range/alignment error
- rom_en  out  1  ROM read strobe
- rom_a  out  AW  ROM word index = granted addr[AW+1:2]
- rom_q  in  DW  ROM output, valid the cycle after rom_en

## Operation
- Each cycle, at most one grant. d_req wins unless the starvation guard is active.
- run_cnt (4-bit) counts consecutive data grants made while if_req=1. Guard active when run_cnt == MAX_DATA_RUN and if_req=1; fetch is then granted even if d_req=1.
- run_cnt clears on any fetch grant or any cycle with if_req=0. Otherwise it increments on a data grant and saturates at MAX_DATA_RUN.
- Address check on the granted address:
  - ok = (addr[1:0]==0) and (addr[31:AW+2]==0).
  - ok: rom_en=1, rom_a=addr[AW+1:2].
  - not ok: ack still issued, rom_en=0, and the response returns rdata=0 with err=1.
- Response tracking: a registered owner flag {none, fetch, data} plus a registered err bit. Next cycle, the owner's rvalid=1 and rdata=err ? 0 : rom_q.
- if_rdata and d_rdata each hold the last returned word between responses via holding registers, updated only on the respective rvalid.
- Throughput is one access per cycle, fully pipelined. A grant may coincide with the previous grant's response.
- No requests: rom_en=0, rom_a holds its last value, no acks.

## Timing
- Grant in cycle t gives rvalid in cycle t+1. Latency is 1 cycle; no other stalls.
- ack is combinational from req and run_cnt. A requester must keep req and addr stable until ack.
- Reset values: if_ack=d_ack=0, if_rvalid=d_rvalid=0, if_err=d_err=0, if_rdata=d_rdata=0, rom_en=0, rom_a=0, run_cnt=0, owner=none.
- While rst=1, all acks and rom_en are forced to 0.
- Reset mid-access: the pending response is discarded, and no rvalid is emitted after reset release.
- Simultaneous if_req and d_req with run_cnt<MAX_DATA_RUN: data granted, fetch waits.
- Back-to-back data requests with fetch waiting: exactly MAX_DATA_RUN data grants, then one fetch grant, then data again.

## Structure
- Shared package rom_arb_pkg:
  - owner encoding (OWN_NONE=2'd0, OWN_IF=2'd1, OWN_D=2'd2)
  - default AW/DW
  - ROM base constant (byte 0x00000000)
- One sub-module, rom_addr_check: combinational ok/index extraction. It is instantiated twice, once per requester.
- Everything else lives in rom_port_arbiter: the grant logic, run_cnt, response registers and holding registers.

## Test plan
- Reset, then if_req=1 with if_addr=0x0: if_ack in cycle 0, rom_a=0x00, if_rvalid in cycle 1, if_rdata=rom_q (e.g. 0x201D1000), if_err=0.
- if_req and d_req both held high for 6 cycles (MAX_DATA_RUN=2): grant order D,D,IF,D,D,IF; rvalid pattern matches one cycle later.
- d_addr=0x00000206 (misaligned): d_ack=1, rom_en=0, next cycle d_rvalid=1, d_rdata=0, d_err=1.
- d_addr=0x00000200 (index 128, out of range for AW=7): same result, d_err=1, d_rdata=0.
- Streaming fetch of 0x0,0x4,0x8 back-to-back: if_rvalid high on 3 consecutive cycles with rom_a=0,1,2; if_rdata holds the third word afterwards.
- Assert rst in the cycle after a data grant: no d_rvalid ever appears; all outputs read 0 during and after reset until a new grant.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared definitions for the ROM port arbiter: response owner encoding,
// default geometry and the ROM base address.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int          DEF_AW   = 7;
  localparam int          DEF_DW   = 32;
  localparam logic [31:0] ROM_BASE = 32'h0000_0000;

endpackage

// File: rtl/rom_addr_check.sv
// Combinational range/alignment check and word-index extraction for one
// requester's byte address.
module rom_addr_check
  import rom_arb_pkg::*;
#(
  parameter int AW = DEF_AW
) (
  input  logic [31:0]   addr,
  output logic          ok,
  output logic [AW-1:0] idx
);

  logic [31:0] offset_s;

  // Offset from the ROM base; only word-aligned offsets inside the array pass.
  always_comb begin
    offset_s = addr - ROM_BASE;
    ok       = (offset_s[1:0] == 2'b00) && (offset_s[31:AW+2] == {(30-AW){1'b0}});
    idx      = offset_s[AW+1:2];
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one registered single-port ROM between instruction fetch and data
// loads: data-first priority with a fetch starvation guard, 1-cycle responses.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int MAX_DATA_RUN = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_ack,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  output logic          if_err,
  input  logic          d_req,
  input  logic [31:0]   d_addr,
  output logic          d_ack,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          rom_en,
  output logic [AW-1:0] rom_a,
  input  logic [DW-1:0] rom_q
);

  localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);

  logic          if_ok_s, d_ok_s;
  logic [AW-1:0] if_idx_s, d_idx_s;
  logic          guard_s;
  logic          if_ack_s, d_ack_s;
  logic          gnt_ok_s;
  logic [AW-1:0] gnt_idx_s;
  logic          rom_en_s;
  logic [AW-1:0] rom_a_s;
  logic [DW-1:0] resp_data_s;

  logic [3:0]    run_cnt_r;
  owner_e        owner_r;
  logic          err_r;
  logic [AW-1:0] rom_a_r;
  logic [DW-1:0] if_hold_r, d_hold_r;

  rom_addr_check #(.AW(AW)) u_if_chk (.addr(if_addr), .ok(if_ok_s), .idx(if_idx_s));
  rom_addr_check #(.AW(AW)) u_d_chk  (.addr(d_addr),  .ok(d_ok_s),  .idx(d_idx_s));

  // Grant selection: data first unless fetch has waited out MAX_DATA_RUN data grants.
  always_comb begin
    guard_s  = if_req && (run_cnt_r == RUN_MAX);
    if_ack_s = 1'b0;
    d_ack_s  = 1'b0;
    if (rst) begin
      if_ack_s = 1'b0;
      d_ack_s  = 1'b0;
    end else if (d_req && !guard_s) begin
      d_ack_s = 1'b1;
    end else if (if_req) begin
      if_ack_s = 1'b1;
    end else begin
      if_ack_s = 1'b0;
      d_ack_s  = 1'b0;
    end
  end

  // ROM strobe/index for the granted address; a rejected address reads nothing.
  always_comb begin
    gnt_ok_s  = 1'b0;
    gnt_idx_s = rom_a_r;
    if (d_ack_s) begin
      gnt_ok_s  = d_ok_s;
      gnt_idx_s = d_idx_s;
    end else if (if_ack_s) begin
      gnt_ok_s  = if_ok_s;
      gnt_idx_s = if_idx_s;
    end else begin
      gnt_ok_s  = 1'b0;
      gnt_idx_s = rom_a_r;
    end
    rom_en_s = gnt_ok_s;
    rom_a_s  = rom_en_s ? gnt_idx_s : rom_a_r;
  end

  // Response word: an errored access returns zero instead of ROM contents.
  always_comb begin
    resp_data_s = err_r ? {DW{1'b0}} : rom_q;
  end

  // Run counter, response owner/error tracking and last driven ROM index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt_r <= 4'd0;
      owner_r   <= OWN_NONE;
      err_r     <= 1'b0;
      rom_a_r   <= {AW{1'b0}};
    end else begin
      if (if_ack_s || !if_req) begin
        run_cnt_r <= 4'd0;
      end else if (d_ack_s && (run_cnt_r != RUN_MAX)) begin
        run_cnt_r <= run_cnt_r + 4'd1;
      end else begin
        run_cnt_r <= run_cnt_r;
      end
      if (d_ack_s) begin
        owner_r <= OWN_D;
        err_r   <= !d_ok_s;
      end else if (if_ack_s) begin
        owner_r <= OWN_IF;
        err_r   <= !if_ok_s;
      end else begin
        owner_r <= OWN_NONE;
        err_r   <= 1'b0;
      end
      rom_a_r <= rom_a_s;
    end
  end

  // Per-requester holding registers keep the last returned word visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_hold_r <= {DW{1'b0}};
      d_hold_r  <= {DW{1'b0}};
    end else begin
      if (owner_r == OWN_IF) begin
        if_hold_r <= resp_data_s;
      end else begin
        if_hold_r <= if_hold_r;
      end
      if (owner_r == OWN_D) begin
        d_hold_r <= resp_data_s;
      end else begin
        d_hold_r <= d_hold_r;
      end
    end
  end

  assign if_ack    = if_ack_s;
  assign d_ack     = d_ack_s;
  assign rom_en    = rom_en_s;
  assign rom_a     = rom_a_s;
  assign if_rvalid = (owner_r == OWN_IF);
  assign d_rvalid  = (owner_r == OWN_D);
  assign if_err    = if_rvalid && err_r;
  assign d_err     = d_rvalid && err_r;
  assign if_rdata  = if_rvalid ? resp_data_s : if_hold_r;
  assign d_rdata   = d_rvalid ? resp_data_s : d_hold_r;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Table-driven bench for rom_port_arbiter with a behavioural ROM and a
// response scoreboard; hand sequences cover reset during an access.
module tb_rom_port_arbiter;
  import rom_arb_pkg::*;

  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, d_req;
  logic [31:0]   if_addr, d_addr;
  logic          if_ack, d_ack, if_rvalid, d_rvalid, if_err, d_err, rom_en;
  logic [DW-1:0] if_rdata, d_rdata;
  logic [AW-1:0] rom_a;
  logic [DW-1:0] rom_q = 32'h0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic [31:0] da;
    logic        eia;
    logic        eda;
    logic        een;
    logic [6:0]  ea;
  } vec_t;

  typedef struct {
    logic [1:0]  own;
    logic [31:0] data;
    logic        err;
  } resp_t;

  vec_t        tbl[15];
  resp_t       sb[$];
  logic [31:0] if_hold_m, d_hold_m;

  rom_port_arbiter #(.AW(AW), .DW(DW), .MAX_DATA_RUN(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_addr(d_addr), .d_ack(d_ack), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .rom_en(rom_en), .rom_a(rom_a), .rom_q(rom_q)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [6:0] i);
    return 32'h201D1000 + {25'd0, i} * 32'h00010203;
  endfunction

  always @(posedge clk) if (rom_en) rom_q <= rom_word(rom_a);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic resp_t mk_resp(input logic [1:0] own, input logic [31:0] a);
    resp_t r;
    logic  ok;
    ok     = (a[1:0] == 2'b00) && (a < 32'h200);
    r.own  = own;
    r.err  = !ok;
    r.data = ok ? rom_word(a[8:2]) : 32'h0;
    return r;
  endfunction

  task automatic sb_reset();
    resp_t n;
    n.own = OWN_NONE; n.data = 32'h0; n.err = 1'b0;
    sb.delete();
    sb.push_back(n);
    if_hold_m = 32'h0;
    d_hold_m  = 32'h0;
  endtask

  task automatic step(input vec_t v);
    resp_t e, n;
    if_req = v.ir; if_addr = v.ia; d_req = v.dr; d_addr = v.da;
    @(negedge clk);
    chk("if_ack", {31'd0, if_ack}, {31'd0, v.eia});
    chk("d_ack", {31'd0, d_ack}, {31'd0, v.eda});
    chk("rom_en", {31'd0, rom_en}, {31'd0, v.een});
    chk("rom_a", {25'd0, rom_a}, {25'd0, v.ea});
    e = sb.pop_front();
    chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, e.own == OWN_IF});
    chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, e.own == OWN_D});
    chk("if_err", {31'd0, if_err}, {31'd0, (e.own == OWN_IF) && e.err});
    chk("d_err", {31'd0, d_err}, {31'd0, (e.own == OWN_D) && e.err});
    if (e.own == OWN_IF) if_hold_m = e.data;
    if (e.own == OWN_D)  d_hold_m  = e.data;
    chk("if_rdata", if_rdata, if_hold_m);
    chk("d_rdata", d_rdata, d_hold_m);
    if (v.eda)      n = mk_resp(OWN_D, v.da);
    else if (v.eia) n = mk_resp(OWN_IF, v.ia);
    else            n = mk_resp(OWN_NONE, 32'h0);
    sb.push_back(n);
    @(posedge clk); #1;
  endtask

  task automatic rst_cycle(input logic ir, input logic dr);
    rst = 1'b1; if_req = ir; d_req = dr; if_addr = 32'h4; d_addr = 32'h8;
    @(negedge clk);
    chk("rst_if_ack", {31'd0, if_ack}, 32'h0);
    chk("rst_d_ack", {31'd0, d_ack}, 32'h0);
    chk("rst_rom_en", {31'd0, rom_en}, 32'h0);
    chk("rst_rom_a", {25'd0, rom_a}, 32'h0);
    chk("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'h0);
    chk("rst_err", {30'd0, if_err, d_err}, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 7'd0};
    tbl[1]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 7'd0};
    tbl[2]  = '{1'b1, 32'h10,  1'b1, 32'h40,  1'b0, 1'b1, 1'b1, 7'd16};
    tbl[3]  = '{1'b1, 32'h10,  1'b1, 32'h40,  1'b0, 1'b1, 1'b1, 7'd16};
    tbl[4]  = '{1'b1, 32'h10,  1'b1, 32'h40,  1'b1, 1'b0, 1'b1, 7'd4};
    tbl[5]  = '{1'b1, 32'h10,  1'b1, 32'h40,  1'b0, 1'b1, 1'b1, 7'd16};
    tbl[6]  = '{1'b1, 32'h10,  1'b1, 32'h40,  1'b0, 1'b1, 1'b1, 7'd16};
    tbl[7]  = '{1'b1, 32'h10,  1'b1, 32'h40,  1'b1, 1'b0, 1'b1, 7'd4};
    tbl[8]  = '{1'b0, 32'h0,   1'b1, 32'h206, 1'b0, 1'b1, 1'b0, 7'd4};
    tbl[9]  = '{1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 7'd4};
    tbl[10] = '{1'b1, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 7'd0};
    tbl[11] = '{1'b1, 32'h4,   1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 7'd1};
    tbl[12] = '{1'b1, 32'h8,   1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 7'd2};
    tbl[13] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 7'd2};
    tbl[14] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 7'd2};

    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; if_addr = 32'h0; d_addr = 32'h0;
    rst_cycle(1'b0, 1'b0);
    rst_cycle(1'b0, 1'b0);
    rst = 1'b0;
    sb_reset();

    for (int i = 0; i < 15; i++) step(tbl[i]);

    // Reset lands in the cycle after a data grant: response must vanish.
    step('{1'b0, 32'h0, 1'b1, 32'h8, 1'b0, 1'b1, 1'b1, 7'd2});
    rst_cycle(1'b0, 1'b0);
    rst_cycle(1'b1, 1'b1);
    rst = 1'b0;
    sb_reset();
    step('{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 7'd0});
    step('{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 7'd0});
    step('{1'b1, 32'h4, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 7'd1});
    step('{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 7'd1});
    step('{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 7'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
